// File: rtl/pilha_pkg.sv
// Shared definitions for the operand-stack controller: command encodings and FSM states.
// The control unit imports the same op constants to issue commands.
package pilha_pkg;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_POP2  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_A,
    ST_WAIT_A,
    ST_RD_B,
    ST_WAIT_B,
    ST_DONE
  } state_e;

endpackage

// File: rtl/pilha_ctrl.sv
// Operand-stack controller: sequences push/pop/pop2/clear onto an external single-port RAM.
// Define PILHA_STICKY_ERR_EN to make err_ovf/err_unf sticky until reset or CLEAR.
module pilha_ctrl
  import pilha_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic                     cmd_ready,
  output logic                     done,
  output logic [DATA_W-1:0]        data_a,
  output logic [DATA_W-1:0]        data_b,
  output logic                     err_ovf,
  output logic                     err_unf,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_wren,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);

  state_e              state_q;
  logic [1:0]          op_q;
  logic [AW:0]         count_q;
  logic [DATA_W-1:0]   data_a_q;
  logic [DATA_W-1:0]   data_b_q;
  logic                done_q;
  logic                err_ovf_q;
  logic                err_unf_q;
  logic [AW-1:0]       mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_wren_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PUSH;
      count_q     <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      done_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
    end else begin
      // Memory-bus outputs default to idle; each state that uses the bus re-drives them.
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
`ifndef PILHA_STICKY_ERR_EN
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            case (cmd_op)
              OP_PUSH: begin
                if (count_q == CNT_FULL) begin
                  err_ovf_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= ST_DONE;
                end else begin
                  mem_wren_q  <= 1'b1;
                  mem_addr_q  <= count_q[AW-1:0];
                  mem_wdata_q <= cmd_data;
                  state_q     <= ST_WR;
                end
              end
              OP_POP, OP_POP2: begin
                if ((cmd_op == OP_POP && count_q == '0) ||
                    (cmd_op == OP_POP2 && count_q < CNT_TWO)) begin
                  err_unf_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= ST_DONE;
                end else begin
                  mem_addr_q <= count_q[AW-1:0] - AW'(1);
                  state_q    <= ST_RD_A;
                end
              end
              default: begin
                count_q   <= '0;
                done_q    <= 1'b1;
                state_q   <= ST_DONE;
`ifdef PILHA_STICKY_ERR_EN
                err_ovf_q <= 1'b0;
                err_unf_q <= 1'b0;
`endif
              end
            endcase
          end
        end
        ST_WR: begin
          count_q <= count_q + CNT_ONE;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_RD_A: state_q <= ST_WAIT_A;
        ST_WAIT_A: begin
          data_a_q <= mem_rdata;
          if (op_q == OP_POP) begin
            count_q <= count_q - CNT_ONE;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            mem_addr_q <= count_q[AW-1:0] - AW'(2);
            state_q    <= ST_RD_B;
          end
        end
        ST_RD_B: state_q <= ST_WAIT_B;
        ST_WAIT_B: begin
          data_b_q <= mem_rdata;
          count_q  <= count_q - CNT_TWO;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reset gates the handshake and the write strobe in the same cycle it is raised.
  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign mem_wren  = mem_wren_q && !reset;

  assign done      = done_q;
  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;
  assign count     = count_q;
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_pilha_ctrl.sv
// Bench for pilha_ctrl (DEPTH=4): directed scenarios then random commands against a queue model.
`timescale 1ns/1ps
module tb_pilha_ctrl;
  import pilha_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              cmd_ready, done, err_ovf, err_unf, full, empty, mem_wren;
  logic [DATA_W-1:0] data_a, data_b, mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [AW:0]       count;
  logic [AW-1:0]     mem_addr;

  pilha_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .done(done), .data_a(data_a),
    .data_b(data_b), .err_ovf(err_ovf), .err_unf(err_unf), .count(count),
    .full(full), .empty(empty), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // External stack RAM: synchronous write, registered read
  logic [DATA_W-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  always @(posedge clock) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [DATA_W-1:0] stk [$];
  logic [DATA_W-1:0] exp_a = '0;
  logic [DATA_W-1:0] exp_b = '0;
  bit sticky_ovf = 0;
  bit sticky_unf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    exp_a = '0;
    exp_b = '0;
    sticky_ovf = 0;
    sticky_unf = 0;
  endtask

  // Issues one command from a negedge and returns observations; ends at the negedge of the idle cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, output int lat,
                         output int nwr, output logic [1:0] wa, output logic [7:0] wd,
                         output logic [1:0] r1, output logic [1:0] r3,
                         output logic eo, output logic eu);
    lat = -1; nwr = 0; wa = '0; wd = '0; r1 = '0; r3 = '0; eo = 1'b0; eu = 1'b0;
    chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(negedge clock);
      if (mem_wren) begin nwr++; wa = mem_addr; wd = mem_wdata; end
      if (k == 1) r1 = mem_addr;
      if (k == 3) r3 = mem_addr;
      if (done) begin
        lat = k; eo = err_ovf; eu = err_unf;
        chk("ready_low_in_done", {31'd0, cmd_ready}, 32'd0);
      end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clock);
  endtask

  task automatic cmd_check(input logic [1:0] op, input logic [7:0] d);
    int lat, nwr, sz, x_lat, x_nwr;
    logic [1:0] wa, r1, r3;
    logic [7:0] wd;
    logic eo, eu;
    bit x_ovf, x_unf, x_eo_done, x_eu_done, x_eo_idle, x_eu_idle;
    sz = stk.size(); x_ovf = 0; x_unf = 0; x_nwr = 0; x_lat = 1;
    case (op)
      OP_PUSH:  if (sz == DEPTH) x_ovf = 1; else begin x_lat = 2; x_nwr = 1; end
      OP_POP:   if (sz == 0) x_unf = 1; else x_lat = 3;
      OP_POP2:  if (sz < 2) x_unf = 1; else x_lat = 5;
      default:  x_lat = 1;
    endcase
    run_cmd(op, d, lat, nwr, wa, wd, r1, r3, eo, eu);
    chk("latency", lat, x_lat);
    chk("write_cycles", nwr, x_nwr);
    if (op == OP_PUSH && !x_ovf) begin
      chk("push_addr", {30'd0, wa}, sz);
      chk("push_wdata", {24'd0, wd}, {24'd0, d});
      stk.push_back(d);
    end
    if (op == OP_POP && !x_unf) exp_a = stk.pop_back();
    if (op == OP_POP2 && !x_unf) begin
      chk("pop2_addr_a", {30'd0, r1}, sz - 1);
      chk("pop2_addr_b", {30'd0, r3}, sz - 2);
      exp_a = stk.pop_back();
      exp_b = stk.pop_back();
    end
    if (op == OP_CLEAR) begin
      stk.delete();
      sticky_ovf = 0;
      sticky_unf = 0;
    end
    if (x_ovf) sticky_ovf = 1;
    if (x_unf) sticky_unf = 1;
`ifdef PILHA_STICKY_ERR_EN
    x_eo_done = sticky_ovf; x_eu_done = sticky_unf;
    x_eo_idle = sticky_ovf; x_eu_idle = sticky_unf;
`else
    x_eo_done = x_ovf; x_eu_done = x_unf;
    x_eo_idle = 0; x_eu_idle = 0;
`endif
    chk("err_ovf_done", {31'd0, eo}, {31'd0, x_eo_done});
    chk("err_unf_done", {31'd0, eu}, {31'd0, x_eu_done});
    chk("err_ovf_idle", {31'd0, err_ovf}, {31'd0, x_eo_idle});
    chk("err_unf_idle", {31'd0, err_unf}, {31'd0, x_eu_idle});
    chk("data_a", {24'd0, data_a}, {24'd0, exp_a});
    chk("data_b", {24'd0, data_b}, {24'd0, exp_b});
    chk("count", {29'd0, count}, stk.size());
    chk("full", {31'd0, full}, {31'd0, stk.size() == DEPTH});
    chk("empty", {31'd0, empty}, {31'd0, stk.size() == 0});
    $display("[TB] cmd op=%0d data=%02h lat=%0d count=%0d a=%02h b=%02h ovf=%0b unf=%0b",
             op, d, lat, count, data_a, data_b, eo, eu);
  endtask

  initial begin
    int r;
    logic [1:0] op;
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_wren", {31'd0, mem_wren}, 32'd0);
    chk("rst_data_a", {24'd0, data_a}, 32'd0);
    chk("rst_errs", {30'd0, err_ovf, err_unf}, 32'd0);
    reset = 1'b0;
    model_reset();
    @(negedge clock);

    // Push three, then POP2
    cmd_check(OP_PUSH, 8'h11);
    cmd_check(OP_PUSH, 8'h22);
    cmd_check(OP_PUSH, 8'h33);
    cmd_check(OP_POP2, 8'h00);
    // Fill to four, then overflow
    cmd_check(OP_PUSH, 8'h22);
    cmd_check(OP_PUSH, 8'h33);
    cmd_check(OP_PUSH, 8'h44);
    cmd_check(OP_PUSH, 8'h55);
    cmd_check(OP_POP, 8'h00);
    cmd_check(OP_PUSH, 8'h66);
    cmd_check(OP_CLEAR, 8'h00);
    // Underflow with one entry, then POP empties
    cmd_check(OP_PUSH, 8'h77);
    cmd_check(OP_POP2, 8'h00);
    cmd_check(OP_POP, 8'h00);
    cmd_check(OP_POP, 8'h00);
    // CLEAR with three entries
    cmd_check(OP_PUSH, 8'h01);
    cmd_check(OP_PUSH, 8'h02);
    cmd_check(OP_PUSH, 8'h03);
    cmd_check(OP_CLEAR, 8'h00);

    // Reset during WAIT_A of a POP
    cmd_check(OP_PUSH, 8'h99);
    cmd_valid = 1'b1; cmd_op = OP_POP; cmd_data = '0;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("ready_in_reset", {31'd0, cmd_ready}, 32'd0);
    repeat (2) begin
      @(negedge clock);
      chk("no_done_after_reset", {31'd0, done}, 32'd0);
    end
    reset = 1'b0;
    model_reset();
    #1;
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    chk("count_after_reset", {29'd0, count}, 32'd0);
    chk("empty_after_reset", {31'd0, empty}, 32'd1);
    chk("data_a_after_reset", {24'd0, data_a}, 32'd0);
    $display("[TB] reset during POP wait: count=%0d ready=%0b", count, cmd_ready);

    // Reset during the WR cycle of a PUSH must suppress the write
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 8'hAB;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    reset = 1'b1;
    #1 chk("wren_suppressed", {31'd0, mem_wren}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    chk("ram_kept", {24'd0, ram[0]}, 32'h99);
    chk("count_after_wr_reset", {29'd0, count}, 32'd0);
    $display("[TB] reset during PUSH write: ram0=%02h count=%0d", ram[0], count);
    @(negedge clock);

    // Random commands
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3 || r == 9) op = OP_PUSH;
      else if (r <= 5) op = OP_POP;
      else if (r <= 7) op = OP_POP2;
      else op = OP_CLEAR;
      cmd_check(op, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
